// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (no handshakes in this package).
package mole_pkg;

  // Game phases; the encoding is internal to the scheduler.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    UP   = 3'd2,
    GAP  = 3'd3,
    OVER = 3'd4
  } state_e;

  localparam int NUM_OVALS = 5;
  localparam int SCORE_MAX = 255;

  // Folds a 3-bit random value onto 0..4, then steps past the current oval
  // so the same hole never shows a mole twice in a row.
  function automatic logic [2:0] pick_oval(input logic [2:0] rnd,
                                           input logic [2:0] cur);
    logic [2:0] cand;
    cand = (rnd < 3'(NUM_OVALS)) ? rnd : rnd - 3'd3;
    if (cand == cur) begin
      cand = (cand == 3'(NUM_OVALS - 1)) ? 3'd0 : cand + 3'd1;
    end
    return cand;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR used as the mole position source.
// Latency: advances one step every clock; reset loads the seed.
// Backpressure: none, free-running.
module mole_lfsr #(
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting Galois step: feedback taps applied when the LSB falls out.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ MASK;
    end
  end

  // State register; a nonzero seed keeps the sequence off the all-zero lockup.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks ovals, times mole up/gap, scores hits and misses.
// Latency: all outputs registered; a hit shows on score/hit_pulse one clock after the press edge.
// Backpressure: none; tick paces the game, start is a level request honoured only in IDLE/OVER.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          UP_TICKS   = 50,
  parameter int          GAP_TICKS  = 25,
  parameter int          MAX_MISSES = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [4:0] hit_btn,
  output logic [2:0] oval_select,
  output logic       mole_up,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       game_over,
  output logic       hit_pulse
);

  localparam int CNT_W = 16;

  state_e           state_q, state_d;
  logic [2:0]       oval_q, oval_d;
  logic             mole_up_q;
  logic [7:0]       score_q, score_d;
  logic [2:0]       misses_q, misses_d;
  logic             game_over_q;
  logic             hit_pulse_q, hit_pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       btn_prev_q;

  logic [15:0]      lfsr_q;
  logic             lfsr_unused;
  logic [4:0]       btn_rise;
  logic             hit;
  logic             expire;
  logic [2:0]       misses_inc;

  mole_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Only the low three bits feed the oval choice.
  assign lfsr_unused = ^lfsr_q[15:3];

  // Press detection and timer expiry; expiry lands on the N-th tick after load.
  always_comb begin
    btn_rise   = hit_btn & ~btn_prev_q;
    hit        = (state_q == UP) && btn_rise[oval_q];
    expire     = tick && (cnt_q == CNT_W'(1));
    misses_inc = misses_q + 3'd1;
  end

  // Next-state and datapath updates; a hit wins over a same-cycle expiry.
  always_comb begin
    state_d     = state_q;
    oval_d      = oval_q;
    score_d     = score_q;
    misses_d    = misses_q;
    cnt_d       = cnt_q;
    hit_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PICK;
        end
      end

      PICK: begin
        oval_d  = pick_oval(lfsr_q[2:0], oval_q);
        cnt_d   = CNT_W'(UP_TICKS);
        state_d = UP;
      end

      UP: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (hit) begin
          score_d     = (score_q == 8'(SCORE_MAX)) ? score_q : score_q + 8'd1;
          hit_pulse_d = 1'b1;
          cnt_d       = CNT_W'(GAP_TICKS);
          state_d     = GAP;
        end else if (expire) begin
          misses_d = misses_inc;
          if (misses_inc == 3'(MAX_MISSES)) begin
            cnt_d   = '0;
            state_d = OVER;
          end else begin
            cnt_d   = CNT_W'(GAP_TICKS);
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (expire) begin
          state_d = PICK;
        end
      end

      OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = PICK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; mole_up/game_over are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      oval_q      <= '0;
      mole_up_q   <= 1'b0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
      hit_pulse_q <= 1'b0;
      cnt_q       <= '0;
      btn_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      oval_q      <= oval_d;
      mole_up_q   <= (state_d == UP);
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= (state_d == OVER);
      hit_pulse_q <= hit_pulse_d;
      cnt_q       <= cnt_d;
      btn_prev_q  <= hit_btn;
    end
  end

  assign oval_select = oval_q;
  assign mole_up     = mole_up_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign game_over   = game_over_q;
  assign hit_pulse   = hit_pulse_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short timers and a tick every cycle.
// Latency: inputs driven 1 ns after posedge, outputs sampled at that point.
// Backpressure: n/a.
module tb_mole_scheduler;

  localparam int UP_T  = 4;
  localparam int GAP_T = 2;
  localparam int MAX_M = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [4:0] hit_btn;
  logic [2:0] oval_select;
  logic       mole_up;
  logic [7:0] score;
  logic [2:0] misses;
  logic       game_over;
  logic       hit_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  mole_scheduler #(
    .UP_TICKS   (UP_T),
    .GAP_TICKS  (GAP_T),
    .MAX_MISSES (MAX_M),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .hit_btn     (hit_btn),
    .oval_select (oval_select),
    .mole_up     (mole_up),
    .score       (score),
    .misses      (misses),
    .game_over   (game_over),
    .hit_pulse   (hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a mole appears, bounded so a stuck design cannot hang the run.
  task automatic wait_up();
    for (int i = 0; i < 20 && !mole_up; i++) begin
      step();
    end
    chk("wait_up", mole_up, 1);
  endtask

  // Wait for a mole and whack it on the first UP edge; returns the oval hit.
  task automatic hit_mole(output logic [2:0] ov);
    wait_up();
    ov      = oval_select;
    hit_btn = 5'b00001 << oval_select;
    step();
    hit_btn = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ov;
    logic [2:0] prev;
    int         wrong;

    rst     = 1'b1;
    tick    = 1'b1;
    start   = 1'b0;
    hit_btn = '0;
    step();
    step();
    chk("rst_oval", oval_select, 0);
    chk("rst_mole_up", mole_up, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_hit_pulse", hit_pulse, 0);
    rst = 1'b0;
    step();
    chk("idle_mole_up", mole_up, 0);

    // Start: one PICK cycle, then the mole shows.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pick_mole_up", mole_up, 0);
    step();
    chk("up_mole_up", mole_up, 1);
    chk("up_oval_range", oval_select < 3'd5, 1);

    // Hit in the second UP cycle.
    step();
    hit_btn = 5'b00001 << oval_select;
    step();
    hit_btn = '0;
    chk("hit_score", score, 1);
    chk("hit_pulse_on", hit_pulse, 1);
    chk("hit_mole_down", mole_up, 0);
    step();
    chk("hit_pulse_off", hit_pulse, 0);
    chk("gap_mole_up", mole_up, 0);
    step();
    chk("pick2_mole_up", mole_up, 0);
    step();
    chk("up2_mole_up", mole_up, 1);

    // Three unanswered moles end the game.
    for (int k = 1; k <= 3; k++) begin
      repeat (3) step();
      chk("miss_still_up", mole_up, 1);
      step();
      chk("miss_mole_down", mole_up, 0);
      chk("miss_count", misses, k);
      if (k < 3) begin
        chk("miss_not_over", game_over, 0);
        wait_up();
      end
    end
    chk("over_flag", game_over, 1);
    chk("over_score_kept", score, 1);
    repeat (3) step();
    chk("over_mole_up", mole_up, 0);
    chk("over_flag_hold", game_over, 1);
    chk("over_misses_hold", misses, 3);

    // Restart from OVER.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_over", game_over, 0);
    step();
    chk("restart_mole_up", mole_up, 1);

    // Hit landing on the expiry tick counts as a hit only.
    repeat (3) step();
    chk("late_still_up", mole_up, 1);
    hit_btn = 5'b00001 << oval_select;
    step();
    hit_btn = '0;
    chk("late_hit_score", score, 1);
    chk("late_hit_misses", misses, 0);
    chk("late_hit_pulse", hit_pulse, 1);

    // Wrong button: scored as a miss.
    wait_up();
    wrong   = (int'(oval_select) + 1) % 5;
    hit_btn = 5'b00001 << wrong;
    repeat (4) step();
    chk("wrong_mole_down", mole_up, 0);
    chk("wrong_score", score, 1);
    chk("wrong_misses", misses, 1);

    // Every button held from GAP into UP: no rising edge, so no hit.
    hit_btn = 5'h1F;
    wait_up();
    step();
    chk("held_no_pulse", hit_pulse, 0);
    repeat (3) step();
    chk("held_score", score, 1);
    chk("held_misses", misses, 2);
    hit_btn = '0;

    // Drive the score to the ceiling, then one more hit.
    repeat (254) hit_mole(ov);
    chk("sat_reach", score, 255);
    hit_mole(ov);
    chk("sat_hold", score, 255);
    chk("sat_pulse", hit_pulse, 1);
    chk("sat_misses", misses, 2);

    // Reset in the middle of an UP phase.
    wait_up();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_oval", oval_select, 0);
    chk("midrst_mole_up", mole_up, 0);
    chk("midrst_score", score, 0);
    chk("midrst_misses", misses, 0);
    chk("midrst_game_over", game_over, 0);
    chk("midrst_hit_pulse", hit_pulse, 0);
    step();
    chk("midrst_idle", mole_up, 0);

    // 1000 moles: consecutive ovals must always differ.
    start = 1'b1;
    step();
    start = 1'b0;
    prev = '0;
    for (int i = 0; i < 1000; i++) begin
      hit_mole(ov);
      chk("run_oval_range", ov < 3'd5, 1);
      if (i > 0) begin
        chk("run_oval_differs", ov != prev, 1);
      end
      prev = ov;
    end
    chk("run_misses", misses, 0);
    chk("run_score", score, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
